// File: rtl/sum_accumulator.sv
// sum_accumulator: sums blocks of {cout,sum} adder results and
// presents each block total, sample count and wrap flag on a valid/ready port.
module sum_accumulator #(
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 16,
    parameter int BLOCK_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] sum,
    input  logic              cout,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [7:0]        acc_cnt,
    output logic              acc_ovf
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  acc_out_q, acc_out_d;
    logic [7:0]        acc_cnt_q, acc_cnt_d;
    logic              acc_ovf_q, acc_ovf_d;

    logic              accept;
    logic [ACC_W-1:0]  operand;
    logic [ACC_W:0]    add;
    logic [ACC_W-1:0]  acc_upd;
    logic [7:0]        cnt_upd;
    logic              ovf_upd;
    logic              close;

    // in_ready is held low during reset so nothing is accepted then
    assign in_ready = (state_q == ACCUM) && !rst;
    assign accept   = in_valid && in_ready;
    assign operand  = ACC_W'({cout, sum});
    assign add      = {1'b0, acc_q} + {1'b0, operand};
    assign acc_upd  = accept ? add[ACC_W-1:0] : acc_q;
    assign cnt_upd  = accept ? cnt_q + 8'd1 : cnt_q;
    assign ovf_upd  = ovf_q | (accept & add[ACC_W]);
    assign close    = (accept && cnt_upd == 8'(BLOCK_LEN))
                   || (flush && cnt_upd != 8'd0);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        acc_out_d   = acc_out_q;
        acc_cnt_d   = acc_cnt_q;
        acc_ovf_d   = acc_ovf_q;
        unique case (state_q)
            ACCUM: begin
                acc_d = acc_upd;
                cnt_d = cnt_upd;
                ovf_d = ovf_upd;
                if (close) begin
                    state_d     = HOLD;
                    out_valid_d = 1'b1;
                    acc_out_d   = acc_upd;
                    acc_cnt_d   = cnt_upd;
                    acc_ovf_d   = ovf_upd;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = ACCUM;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            acc_out_q   <= '0;
            acc_cnt_q   <= '0;
            acc_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            acc_out_q   <= acc_out_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_ovf_q   <= acc_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign acc_out   = acc_out_q;
    assign acc_cnt   = acc_cnt_q;
    assign acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed vectors for sum_accumulator with
// BLOCK_LEN=4 (dut a) and BLOCK_LEN=255 (dut b).
module tb_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_in_valid = 1'b0, a_cout = 1'b0, a_flush = 1'b0;
    logic        a_out_ready = 1'b1;
    logic [7:0]  a_sum = '0;
    logic        a_in_ready, a_out_valid, a_acc_ovf;
    logic [15:0] a_acc_out;
    logic [7:0]  a_acc_cnt;

    logic        b_in_valid = 1'b0, b_cout = 1'b0, b_flush = 1'b0;
    logic        b_out_ready = 1'b1;
    logic [7:0]  b_sum = '0;
    logic        b_in_ready, b_out_valid, b_acc_ovf;
    logic [15:0] b_acc_out;
    logic [7:0]  b_acc_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sum_accumulator #(.DATA_W(8), .ACC_W(16), .BLOCK_LEN(4)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .sum(a_sum), .cout(a_cout), .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .acc_out(a_acc_out), .acc_cnt(a_acc_cnt), .acc_ovf(a_acc_ovf)
    );

    sum_accumulator #(.DATA_W(8), .ACC_W(16), .BLOCK_LEN(255)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .sum(b_sum), .cout(b_cout), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .acc_out(b_acc_out), .acc_cnt(b_acc_cnt), .acc_ovf(b_acc_ovf)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one 9-bit value on dut a for one edge
    task automatic a_send(input logic [8:0] v, input logic fl);
        a_in_valid = 1'b1;
        {a_cout, a_sum} = v;
        a_flush = fl;
        step();
        a_in_valid = 1'b0;
        a_flush = 1'b0;
    endtask

    task automatic a_block(input string tag, input logic [15:0] acc,
                           input logic [7:0] cnt, input logic ovf);
        check({tag, "_valid"}, a_out_valid, 1);
        check({tag, "_acc"}, a_acc_out, acc);
        check({tag, "_cnt"}, a_acc_cnt, cnt);
        check({tag, "_ovf"}, a_acc_ovf, ovf);
        check({tag, "_rdy"}, a_in_ready, 0);
    endtask

    initial begin
        // reset
        step();
        check("rst_in_ready", a_in_ready, 0);
        step();
        rst = 1'b0;
        #1;
        check("rst_out_valid", a_out_valid, 0);
        check("rst_acc_out", a_acc_out, 0);
        check("rst_acc_cnt", a_acc_cnt, 0);
        check("rst_acc_ovf", a_acc_ovf, 0);
        check("rst_in_ready_rel", a_in_ready, 1);

        // first block: 0 + 15 + 28 + 270 = 313
        a_send(9'd0, 0);
        a_send(9'd15, 0);
        a_send(9'd28, 0);
        check("b1_not_early", a_out_valid, 0);
        a_send({1'b1, 8'd14}, 0);
        a_block("b1", 16'd313, 8'd4, 0);

        // back-to-back: 256 is held through the HOLD cycle
        a_in_valid = 1'b1;
        {a_cout, a_sum} = 9'd256;
        step();
        check("b1_one_cycle", a_out_valid, 0);
        check("b2_rdy_back", a_in_ready, 1);
        step();
        a_send(9'd255, 0);
        a_send(9'd300, 0);
        a_send(9'd100, 0);
        a_block("b2", 16'd911, 8'd4, 0);
        step();
        check("b2_done", a_out_valid, 0);

        // backpressure for 5 cycles with in_valid held
        a_out_ready = 1'b0;
        a_send(9'd1, 0);
        a_send(9'd2, 0);
        a_send(9'd3, 0);
        a_send(9'd4, 0);
        a_in_valid = 1'b1;
        {a_cout, a_sum} = 9'd7;
        for (int i = 0; i < 5; i++) begin
            a_block("bp", 16'd10, 8'd4, 0);
            step();
        end
        a_out_ready = 1'b1;
        step();
        check("bp_release", a_out_valid, 0);
        step();
        a_in_valid = 1'b0;
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
        a_block("bp_next", 16'd7, 8'd1, 0);
        step();

        // early flush after two samples
        a_send(9'd15, 0);
        a_send(9'd28, 0);
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
        a_block("fl2", 16'd43, 8'd2, 0);
        step();

        // flush with an empty block is ignored
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
        check("fl_empty", a_out_valid, 0);
        step();
        check("fl_empty2", a_out_valid, 0);

        // flush together with the third sample
        a_send(9'd20, 0);
        a_send(9'd23, 0);
        a_send(9'd5, 1);
        a_block("fl3", 16'd48, 8'd3, 0);
        step();

        // reset mid-block
        a_send(9'd9, 0);
        a_send(9'd9, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rm_valid", a_out_valid, 0);
        check("rm_acc", a_acc_out, 0);
        check("rm_cnt", a_acc_cnt, 0);
        a_send(9'd1, 0);
        a_send(9'd1, 0);
        a_send(9'd1, 0);
        a_send(9'd1, 0);
        a_block("rm_fresh", 16'd4, 8'd4, 0);
        step();

        // reset during HOLD
        a_out_ready = 1'b0;
        a_send(9'd2, 0);
        a_send(9'd2, 0);
        a_send(9'd2, 0);
        a_send(9'd2, 0);
        a_block("rh_pre", 16'd8, 8'd4, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        a_out_ready = 1'b1;
        check("rh_valid", a_out_valid, 0);
        check("rh_acc", a_acc_out, 0);
        check("rh_cnt", a_acc_cnt, 0);
        check("rh_ovf", a_acc_ovf, 0);
        a_send(9'd3, 0);
        a_send(9'd3, 0);
        a_send(9'd3, 0);
        a_send(9'd3, 0);
        a_block("rh_fresh", 16'd12, 8'd4, 0);
        step();

        // 255 samples of 510 on dut b: 130050 mod 65536 = 64514
        b_in_valid = 1'b1;
        {b_cout, b_sum} = 9'd510;
        for (int i = 0; i < 254; i++) step();
        check("big_not_early", b_out_valid, 0);
        step();
        b_in_valid = 1'b0;
        check("big_valid", b_out_valid, 1);
        check("big_acc", b_acc_out, 64514);
        check("big_cnt", b_acc_cnt, 255);
        check("big_ovf", b_acc_ovf, 1);
        step();
        check("big_done", b_out_valid, 0);
        b_in_valid = 1'b1;
        {b_cout, b_sum} = 9'd15;
        b_flush = 1'b1;
        step();
        b_in_valid = 1'b0;
        b_flush = 1'b0;
        check("big_next_valid", b_out_valid, 1);
        check("big_next_acc", b_acc_out, 15);
        check("big_next_cnt", b_acc_cnt, 1);
        check("big_next_ovf", b_acc_ovf, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
